// File: rtl/gpio_pkg.sv
// Shared definitions for the Avalon-MM GPIO slave: register map, edge modes, INFO layout.
package gpio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
   localparam logic [2:0] ADDR_OUTTGL  = 3'd6;
   localparam logic [2:0] ADDR_INFO    = 3'd7;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_mode_e;

   localparam int INFO_WIDTH_LSB = 0;
   localparam int INFO_MODE_LSB  = 8;

   function automatic logic [31:0] info_word(input int width, input int mode);
      logic [31:0] w;
      w = '0;
      w[INFO_WIDTH_LSB +: 8] = 8'(width);
      w[INFO_MODE_LSB +: 8]  = 8'(mode);
      return w;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser followed by a one-flop history for per-bit edge detection.
module gpio_sync_edge
   import gpio_pkg::*;
#(
   parameter int WIDTH       = 12,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] in_sync_o,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= pin_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign in_sync_o = sync_q[SYNC_STAGES-1];
   assign rise      = in_sync_o & ~prev_q;
   assign fall      = ~in_sync_o & prev_q;

   always_comb begin
      edge_o = rise;
      if (EDGE_MODE == int'(EDGE_FALL))     edge_o = fall;
      else if (EDGE_MODE == int'(EDGE_ANY)) edge_o = rise | fall;
   end

endmodule

// File: rtl/avalon_gpio_ext.sv
// Avalon-MM GPIO slave: direction control, atomic set/clear/toggle, edge capture and masked irq.
module avalon_gpio_ext
   import gpio_pkg::*;
#(
   parameter int          WIDTH       = 12,
   parameter logic [31:0] OUT_RESET   = 32'h0,
   parameter logic [31:0] DIR_RESET   = 32'h0,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_MODE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic             read_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_pulse;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      rd_val;
   logic             wr, rd;
   logic             unused_wd;

   gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
   ) u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin_i     (gpio_in),
      .in_sync_o (in_sync),
      .edge_o    (edge_pulse)
   );

   assign wr        = chipselect & ~write_n;
   assign rd        = chipselect & ~read_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      mask_d     = mask_q;
      cap_clr    = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:    data_out_d = wd;
            ADDR_DIR:     dir_d      = wd;
            ADDR_IRQMASK: mask_d     = wd;
            ADDR_EDGECAP: cap_clr    = wd;
            ADDR_OUTSET:  data_out_d = data_out_q | wd;
            ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
            ADDR_OUTTGL:  data_out_d = data_out_q ^ wd;
            default:      ;
         endcase
      end
      // a fresh edge overrides a same-cycle clear of that bit
      cap_d = (cap_q & ~cap_clr) | edge_pulse;
      irq_d = |(cap_q & mask_q);
   end

   always_comb begin
      rd_val = '0;
      case (address)
         ADDR_DATA:    rd_val = 32'((dir_q & data_out_q) | (~dir_q & in_sync));
         ADDR_DIR:     rd_val = 32'(dir_q);
         ADDR_IRQMASK: rd_val = 32'(mask_q);
         ADDR_EDGECAP: rd_val = 32'(cap_q);
         ADDR_INFO:    rd_val = info_word(WIDTH, EDGE_MODE);
         default:      rd_val = '0;
      endcase
      rdata_d = rd ? rd_val : rdata_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= OUT_RESET[WIDTH-1:0];
         dir_q      <= DIR_RESET[WIDTH-1:0];
         mask_q     <= '0;
         cap_q      <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         mask_q     <= mask_d;
         cap_q      <= cap_d;
         irq_q      <= irq_d;
         rdata_q    <= rdata_d;
      end
   end

   assign gpio_out = data_out_q;
   assign gpio_oe  = dir_q;
   assign irq      = irq_q;
   assign readdata = rdata_q;

endmodule

// File: tb/tb_avalon_gpio_ext.sv
// Directed bench for avalon_gpio_ext with default parameters (WIDTH=12, rising-edge capture).
module tb_avalon_gpio_ext;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [11:0] gpio_in;
   logic [11:0] gpio_out;
   logic [11:0] gpio_oe;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   avalon_gpio_ext dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .gpio_in    (gpio_in),
      .gpio_out   (gpio_out),
      .gpio_oe    (gpio_oe),
      .irq        (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_n     = 1'b1;
   endtask

   // Drive one write across a single rising edge; returns at the following falling edge.
   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      idle();
   endtask

   // One-cycle read; readdata is valid at the falling edge after the strobe edge.
   task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      @(negedge clk);
      idle();
      d = readdata;
   endtask

   logic [31:0] rv;

   initial begin
      idle();
      address = 3'd0; writedata = '0; gpio_in = '0;
      reset_n = 1'b0;
      #22;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      @(negedge clk); reset_n = 1'b1;

      bus_rd(3'd1, rv); chk("rd_dir_reset", rv, 32'h0);
      bus_rd(3'd0, rv); chk("rd_data_reset", rv, 32'h0);
      bus_rd(3'd7, rv); chk("rd_info", rv, 32'h0000_000C);

      // Atomic output ops: A5A -> A5F -> 25F -> 2AF
      bus_wr(3'd0, 32'hFFFF_FA5A); chk("wr_data", 32'(gpio_out), 32'hA5A);
      bus_wr(3'd4, 32'h005);       chk("outset", 32'(gpio_out), 32'hA5F);
      bus_wr(3'd5, 32'h800);       chk("outclr", 32'(gpio_out), 32'h25F);
      bus_wr(3'd6, 32'h0F0);       chk("outtgl", 32'(gpio_out), 32'h2AF);
      bus_rd(3'd4, rv); chk("rd_outset_zero", rv, 32'h0);

      bus_wr(3'd1, 32'hFFF);
      chk("gpio_oe_all", 32'(gpio_oe), 32'hFFF);
      bus_rd(3'd0, rv); chk("rd_data_all_out", rv, 32'h2AF);
      @(negedge clk); @(negedge clk);
      chk("readdata_holds", readdata, 32'h2AF);

      // Direction change keeps data_out; mixed read merges pins and outputs
      bus_wr(3'd1, 32'h0F0);
      chk("dir_keeps_data", 32'(gpio_out), 32'h2AF);
      bus_wr(3'd0, 32'h0A0);
      gpio_in = 12'h30C;
      repeat (4) @(negedge clk);
      bus_rd(3'd0, rv); chk("rd_data_mixed", rv, 32'h3AC);
      bus_rd(3'd3, rv); chk("edgecap_rise", rv, 32'h30C);
      gpio_in = 12'h000;
      repeat (4) @(negedge clk);
      bus_rd(3'd3, rv); chk("edgecap_no_fall", rv, 32'h30C);
      bus_wr(3'd3, 32'hFFF);
      bus_rd(3'd3, rv); chk("edgecap_w1c", rv, 32'h0);
      chk("irq_unmasked", 32'(irq), 32'h0);

      // Edge to irq latency
      bus_wr(3'd2, 32'h001);
      bus_rd(3'd2, rv); chk("rd_irqmask", rv, 32'h001);
      gpio_in = 12'h001;
      @(negedge clk); @(negedge clk);
      @(negedge clk); chk("irq_cycle3", 32'(irq), 32'h0);
      @(negedge clk); chk("irq_cycle4", 32'(irq), 32'h1);
      bus_rd(3'd3, rv); chk("edgecap_bit0", rv, 32'h001);
      bus_wr(3'd3, 32'h001);
      chk("irq_after_clr_1", 32'(irq), 32'h1);
      @(negedge clk); chk("irq_after_clr_2", 32'(irq), 32'h0);

      // Edge and clear in the same cycle: set wins
      gpio_in = 12'h000;
      repeat (4) @(negedge clk);
      gpio_in = 12'h001;
      @(negedge clk);
      @(negedge clk);
      address = 3'd3; writedata = 32'h001; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      idle();
      @(negedge clk); chk("collide_irq", 32'(irq), 32'h1);
      bus_rd(3'd3, rv); chk("collide_edgecap", rv, 32'h001);
      chk("collide_irq_stays", 32'(irq), 32'h1);

      // Simultaneous read and write returns the pre-write value
      @(negedge clk);
      address = 3'd1; writedata = 32'h123; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
      @(negedge clk);
      idle();
      chk("rdwr_old_dir", readdata, 32'h0F0);
      bus_rd(3'd1, rv); chk("rdwr_new_dir", rv, 32'h123);

      // Async reset mid-read with a pending edge in the synchroniser
      gpio_in = 12'h003;
      @(negedge clk);
      address = 3'd3; chipselect = 1'b1; read_n = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset_readdata", readdata, 32'h001);
      reset_n = 1'b0;
      #1;
      chk("async_rst_readdata", readdata, 32'h0);
      chk("async_rst_irq", 32'(irq), 32'h0);
      chk("async_rst_gpio_out", 32'(gpio_out), 32'h0);
      chk("async_rst_gpio_oe", 32'(gpio_oe), 32'h0);
      idle();
      gpio_in = 12'h000;
      @(negedge clk); reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("readdata_zero_until_rd", readdata, 32'h0);
      bus_rd(3'd3, rv); chk("edgecap_after_rst", rv, 32'h0);
      bus_rd(3'd2, rv); chk("irqmask_after_rst", rv, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
